nibble_serial_alu16: RTL

NIBBLE_SERIAL_ALU16 -- requirements
Module: nibble_serial_alu16

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 78 +++++++
 rtl/nibble_serial_alu16.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the nibble-serial ALU: FSM state encodings, datapath
// sizes and the two slice function codes that callers use most often.
//   ST_IDLE / ST_BUSY / ST_DONE : 2-bit FSM state encodings
//   NIBBLES / WIDTH             : number of 4-bit slices and total operand width
//   OP_ADD (use with m=0)       : F = A plus B plus carry
//   OP_XOR (use with m=1)       : F = A xor B
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 16;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b0110;

endpackage

// File: rtl/alu.sv
// alu
// 4-bit ALU slice in the style of the classic '181 with active-high data and
// an active-high carry (Cn=1 adds one, Cn4=1 means carry out).
//   S   : function select
//   A,B : 4-bit operands
//   M   : 1 = logic functions, 0 = arithmetic functions
//   Cn  : carry in
//   F   : 4-bit result
//   Cn4 : carry out, always produced from the arithmetic path so that a
//         chain of slices ripples carry the same way in both modes
module alu (
  input  logic [3:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  input  logic       Cn,
  output logic [3:0] F,
  output logic       Cn4
);

  logic [4:0] w_x;
  logic [4:0] w_y;
  logic [4:0] w_sum;
  logic [3:0] w_logic;

  // Arithmetic functions are expressed as X + Y + Cn so that every code
  // yields a genuine carry out.  The "minus 1" style codes add all ones.
  always_comb begin
    w_x = {1'b0, A};
    w_y = 5'd0;
    case (S)
      4'b0000: begin w_x = {1'b0, A};           w_y = 5'd0;            end
      4'b0001: begin w_x = {1'b0, A | B};       w_y = 5'd0;            end
      4'b0010: begin w_x = {1'b0, A | ~B};      w_y = 5'd0;            end
      4'b0011: begin w_x = 5'd0;                w_y = 5'h0F;           end
      4'b0100: begin w_x = {1'b0, A};           w_y = {1'b0, A & ~B};  end
      4'b0101: begin w_x = {1'b0, A | B};       w_y = {1'b0, A & ~B};  end
      4'b0110: begin w_x = {1'b0, A};           w_y = {1'b0, ~B};      end
      4'b0111: begin w_x = {1'b0, A & ~B};      w_y = 5'h0F;           end
      4'b1000: begin w_x = {1'b0, A};           w_y = {1'b0, A & B};   end
      4'b1001: begin w_x = {1'b0, A};           w_y = {1'b0, B};       end
      4'b1010: begin w_x = {1'b0, A | ~B};      w_y = {1'b0, A & B};   end
      4'b1011: begin w_x = {1'b0, A & B};       w_y = 5'h0F;           end
      4'b1100: begin w_x = {1'b0, A};           w_y = {1'b0, A};       end
      4'b1101: begin w_x = {1'b0, A | B};       w_y = {1'b0, A};       end
      4'b1110: begin w_x = {1'b0, A | ~B};      w_y = {1'b0, A};       end
      default: begin w_x = {1'b0, A};           w_y = 5'h0F;           end
    endcase
    w_sum = w_x + w_y + {4'd0, Cn};
  end

  // Bitwise logic functions used when M=1.
  always_comb begin
    w_logic = 4'h0;
    case (S)
      4'b0000: w_logic = ~A;
      4'b0001: w_logic = ~(A | B);
      4'b0010: w_logic = ~A & B;
      4'b0011: w_logic = 4'h0;
      4'b0100: w_logic = ~(A & B);
      4'b0101: w_logic = ~B;
      4'b0110: w_logic = A ^ B;
      4'b0111: w_logic = A & ~B;
      4'b1000: w_logic = ~A | B;
      4'b1001: w_logic = ~(A ^ B);
      4'b1010: w_logic = B;
      4'b1011: w_logic = A & B;
      4'b1100: w_logic = 4'hF;
      4'b1101: w_logic = A | ~B;
      4'b1110: w_logic = A | B;
      default: w_logic = A;
    endcase
  end

  assign F   = M ? w_logic : w_sum[3:0];
  assign Cn4 = w_sum[4];

endmodule

// File: rtl/nibble_serial_alu16.sv
// nibble_serial_alu16
// 16-bit ALU built from a single 4-bit slice reused over four cycles, least
// significant nibble first, with the carry held in a register between nibbles.
//   clk, rst (sync, active-high) : clock and reset
//   start                        : request an operation (ignored while busy)
//   a, b, s, m, cin              : operands, slice function, mode, carry in;
//                                  captured when the operation is accepted
//   busy                         : high during the four nibble cycles
//   done                         : one-cycle pulse, f/cout/zero valid
//   f, cout, zero                : registered result, nibble-3 carry, f==0
module nibble_serial_alu16
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero
);

  logic [1:0]       r_state;
  logic [1:0]       r_k;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_aQ;
  logic [WIDTH-1:0] r_bQ;
  logic [3:0]       r_sQ;
  logic             r_mQ;

  logic [3:0]       w_aNib;
  logic [3:0]       w_bNib;
  logic [3:0]       w_sliceF;
  logic             w_sliceCn4;
  logic [3:0]       w_base;
  logic [WIDTH-1:0] w_resNext;

  // The nibble counter selects which 4-bit window of the latched operands
  // feeds the shared slice this cycle.
  assign w_base = {r_k, 2'b00};
  assign w_aNib = r_aQ[w_base +: 4];
  assign w_bNib = r_bQ[w_base +: 4];

  alu u_slice (
    .S   (r_sQ),
    .A   (w_aNib),
    .B   (w_bNib),
    .M   (r_mQ),
    .Cn  (r_c),
    .F   (w_sliceF),
    .Cn4 (w_sliceCn4)
  );

  // Result as it will look after this cycle's nibble is written; on the
  // last nibble this is the complete answer, so f and zero can be loaded on
  // the same edge that stores nibble 3.
  always_comb begin
    w_resNext = r_res;
    w_resNext[w_base +: 4] = w_sliceF;
  end

  // Control FSM and datapath registers.  Operands are captured on acceptance
  // so the caller may change the inputs while the operation runs.  DONE can
  // accept a new request directly, giving back-to-back operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= 2'd0;
      r_c     <= 1'b0;
      r_res   <= '0;
      f       <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
      r_aQ    <= '0;
      r_bQ    <= '0;
      r_sQ    <= 4'h0;
      r_mQ    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_aQ    <= a;
            r_bQ    <= b;
            r_sQ    <= s;
            r_mQ    <= m;
            r_c     <= cin;
            r_k     <= 2'd0;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_res <= w_resNext;
          r_c   <= w_sliceCn4;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            f       <= w_resNext;
            cout    <= w_sliceCn4;
            zero    <= (w_resNext == '0);
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign done = (r_state == ST_DONE);

endmodule
